// File: rtl/ysyx_24120013_rf_wb_arbiter.sv
// Register-file writeback arbiter with a WAW/RAW scoreboard.
// Two writeback sources (EXU, LSU) share a single register-file write port.
// Decode marks destination registers pending at issue; the mark is cleared
// when the registered write to that register actually lands.

// One scoreboard entry: a pending bit with set-over-clear priority.
module ysyx_24120013_rf_wb_sb_cell (
    input  logic clk,
    input  logic rst,
    input  logic set_i,
    input  logic clr_i,
    output logic pend_o
);

    logic pend_q, pend_d;

    // Next state: a new issue to this register outranks a retiring write.
    always_comb begin
        pend_d = pend_q;
        if (clr_i) pend_d = 1'b0;
        if (set_i) pend_d = 1'b1;
    end

    // Pending flag, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pend_q <= 1'b0;
        else      pend_q <= pend_d;
    end

    assign pend_o = pend_q;

endmodule

module ysyx_24120013_rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // issue side
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    // EXU writeback
    input  logic                  exu_valid,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    output logic                  exu_ready,
    // LSU writeback
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    // register file write port
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int NREG = 1 << ADDR_WIDTH;

    // Last-grant pointer encoding; reset to LSU so the first tie goes to EXU.
    localparam logic GNT_EXU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

    wb_req_t exu_req, lsu_req, sel_req;

    logic            exu_gnt, lsu_gnt, xfer;
    logic            last_q, last_d;
    logic            rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0] pend_vec;
    logic            iss_fire;

    assign exu_req = '{rd: exu_rd, data: exu_data};
    assign lsu_req = '{rd: lsu_rd, data: lsu_data};

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    // Register 0 is hardwired, so it never needs a storage cell.
    assign pend_vec[0] = 1'b0;

    // Issue is stalled only by an outstanding write to the same destination.
    assign iss_ready = (iss_rd == '0) || !pend_vec[iss_rd];
    assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);

    assign rs1_busy = pend_vec[rs1];
    assign rs2_busy = pend_vec[rs2];

    for (genvar i = 1; i < NREG; i++) begin : g_sb
        logic set_c, clr_c;

        // Per-entry decode of the issue set and the retiring-write clear.
        always_comb begin
            set_c = iss_fire && (iss_rd == ADDR_WIDTH'(i));
            clr_c = rf_wen_q && (rf_waddr_q == ADDR_WIDTH'(i));
        end

        ysyx_24120013_rf_wb_sb_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .set_i  (set_c),
            .clr_i  (clr_c),
            .pend_o (pend_vec[i])
        );
    end

    // ------------------------------------------------------------------
    // Round-robin grant
    // ------------------------------------------------------------------
    // A lone requester is granted at once; on a tie the side that did not
    // win last time goes. Nothing is granted while reset is held.
    always_comb begin
        exu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (rst) begin
            if (exu_valid && lsu_valid) begin
                if (last_q == GNT_LSU) exu_gnt = 1'b1;
                else                   lsu_gnt = 1'b1;
            end else begin
                exu_gnt = exu_valid;
                lsu_gnt = lsu_valid;
            end
        end
    end

    assign exu_ready = exu_gnt;
    assign lsu_ready = lsu_gnt;
    assign xfer      = exu_gnt || lsu_gnt;
    assign sel_req   = lsu_gnt ? lsu_req : exu_req;

    // Pointer moves on every transfer, tie or not.
    always_comb begin
        last_d = last_q;
        if (xfer) last_d = lsu_gnt ? GNT_LSU : GNT_EXU;
    end

    // ------------------------------------------------------------------
    // Register-file write stage
    // ------------------------------------------------------------------
    // A transfer to x0 completes its handshake but never writes; idle
    // cycles keep address/data so the port only toggles on real traffic.
    always_comb begin
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (xfer) begin
            rf_wen_d   = (sel_req.rd != '0);
            rf_waddr_d = sel_req.rd;
            rf_wdata_d = sel_req.data;
        end
    end

    // Write-port and grant-pointer state; reset drops any in-flight write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            last_q     <= GNT_LSU;
        end else begin
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            last_q     <= last_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    // Grants are exclusive and only ever answer a live request.
    a_one_gnt : assert property (@(posedge clk) disable iff (!rst)
        !(exu_ready && lsu_ready));
    a_exu_vld : assert property (@(posedge clk) disable iff (!rst)
        exu_ready |-> exu_valid);
    a_lsu_vld : assert property (@(posedge clk) disable iff (!rst)
        lsu_ready |-> lsu_valid);

endmodule

// File: tb/tb_ysyx_24120013_rf_wb_arbiter.sv
module tb_ysyx_24120013_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          iss_ready;
    logic [AW-1:0] rs1, rs2;
    logic          rs1_busy, rs2_busy;
    logic          exu_valid, lsu_valid;
    logic [AW-1:0] exu_rd, lsu_rd;
    logic [DW-1:0] exu_data, lsu_data;
    logic          exu_ready, lsu_ready;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    ysyx_24120013_rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wen;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wb_exp_t;

    wb_exp_t       exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    // reference model state
    logic [31:0]   m_pend;
    logic          m_last;      // 1: LSU won last
    logic          m_rf_wen;
    logic [AW-1:0] m_rf_a;
    logic [DW-1:0] m_rf_d;
    logic          m_e_rdy, m_l_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend   = '0;
        m_last   = 1'b1;
        m_rf_wen = 1'b0;
        m_rf_a   = '0;
        m_rf_d   = '0;
        m_e_rdy  = 1'b0;
        m_l_rdy  = 1'b0;
        exp_q.delete();
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_rd = '0;
        exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    endtask

    task automatic set_wb(input logic ev, input logic [AW-1:0] erd, input logic [DW-1:0] ed,
                          input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld);
        exu_valid = ev; exu_rd = erd; exu_data = ed;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    endtask

    // One clock: check comb outputs mid-cycle, push the expected write,
    // advance the model at the edge, then pop and compare the write port.
    task automatic step();
        logic    i_rdy;
        wb_exp_t e;
        #3;
        i_rdy   = (iss_rd == 0) || !m_pend[iss_rd];
        m_e_rdy = rst && exu_valid && (!lsu_valid || m_last);
        m_l_rdy = rst && lsu_valid && (!exu_valid || !m_last);
        chk("iss_ready", iss_ready, i_rdy);
        chk("rs1_busy", rs1_busy, (rs1 == 0) ? 1'b0 : m_pend[rs1]);
        chk("rs2_busy", rs2_busy, (rs2 == 0) ? 1'b0 : m_pend[rs2]);
        chk("exu_ready", exu_ready, m_e_rdy);
        chk("lsu_ready", lsu_ready, m_l_rdy);
        chk("dbl_gnt", exu_ready & lsu_ready, 0);
        if (m_e_rdy)      e = '{exu_rd != 0, exu_rd, exu_data};
        else if (m_l_rdy) e = '{lsu_rd != 0, lsu_rd, lsu_data};
        else              e = '{1'b0, m_rf_a, m_rf_d};
        if (rst) exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            if (m_rf_wen) m_pend[m_rf_a] = 1'b0;
            if (iss_valid && i_rdy && iss_rd != 0) m_pend[iss_rd] = 1'b1;
            if (m_e_rdy) m_last = 1'b0;
            if (m_l_rdy) m_last = 1'b1;
            e = exp_q.pop_front();
            m_rf_wen = e.wen; m_rf_a = e.a; m_rf_d = e.d;
        end
        #1;
        chk("rf_wen", rf_wen, m_rf_wen);
        chk("rf_waddr", rf_waddr, m_rf_a);
        chk("rf_wdata", rf_wdata, m_rf_d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [AW-1:0] seq_a [4];
        seq_a[0] = 5'd1; seq_a[1] = 5'd11; seq_a[2] = 5'd2; seq_a[3] = 5'd12;

        // ---- reset state
        rst = 1'b0; idle(); rs1 = 5'd5; rs2 = '0; iss_rd = 5'd5;
        model_reset();
        #1;
        chk("rst_wen", rf_wen, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_iss_ready", iss_ready, 1);
        chk("rst_busy", rs1_busy, 0);
        set_wb(1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
        iss_valid = 1'b1;
        repeat (2) step();
        idle();
        rst = 1'b1;

        // ---- tie round robin: E,L,E,L
        k = 0;
        for (int c = 0; c < 4; c++) begin
            set_wb(1, AW'(1 + c / 2 + (c % 2)), 32'hE000 + c,
                   1, AW'(11 + c / 2), 32'hA000 + c);
            if (c == 2) exu_rd = 5'd2;
            if (c == 3) exu_rd = 5'd3;
            step();
            chk("rr_waddr", rf_waddr, seq_a[c]);
        end
        idle(); step();

        // ---- issue rd5, EXU writes rd5
        rs1 = 5'd5;
        iss_valid = 1'b1; iss_rd = 5'd5;
        step();
        idle();
        set_wb(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
        step();
        chk("wb5_wen", rf_wen, 1);
        chk("wb5_waddr", rf_waddr, 5);
        chk("wb5_wdata", rf_wdata, 32'hDEADBEEF);
        chk("wb5_busy_wen", rs1_busy, 1);
        idle(); step();
        chk("wb5_busy_clr", rs1_busy, 0);
        chk("wb5_wen_drop", rf_wen, 0);

        // ---- WAW stall on rd7
        rs1 = 5'd7;
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        repeat (2) step();
        chk("waw_stall", iss_ready, 0);
        iss_rd = 5'd0;
        step();
        chk("x0_busy7", rs1_busy, 1);
        iss_rd = 5'd7;
        set_wb(1, 5'd7, 32'h77, 0, '0, '0);
        step();
        set_wb(0, '0, '0, 0, '0, '0);
        repeat (3) step();
        idle(); step();

        // ---- LSU write to x0
        rs1 = 5'd0;
        set_wb(0, '0, '0, 1, 5'd0, 32'h1234);
        step();
        chk("x0_wen", rf_wen, 0);
        chk("x0_busy", rs1_busy, 0);
        idle(); step();

        // ---- random traffic
        for (int c = 0; c < 400; c++) begin
            if (!(exu_valid && !m_e_rdy)) begin
                exu_valid = $urandom_range(0, 1);
                exu_rd    = AW'($urandom_range(0, 31));
                exu_data  = $urandom;
            end
            if (!(lsu_valid && !m_l_rdy)) begin
                lsu_valid = $urandom_range(0, 1);
                lsu_rd    = AW'($urandom_range(0, 31));
                lsu_data  = $urandom;
            end
            iss_valid = $urandom_range(0, 1);
            iss_rd    = AW'($urandom_range(0, 31));
            rs1       = AW'($urandom_range(0, 31));
            rs2       = AW'($urandom_range(0, 31));
            step();
        end
        idle(); repeat (2) step();

        // ---- async reset right after a transfer lands
        rs1 = 5'd9;
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        idle();
        set_wb(1, 5'd3, 32'hCAFE, 0, '0, '0);
        step();
        chk("ar_wen_pre", rf_wen, 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_wen", rf_wen, 0);
        chk("ar_busy", rs1_busy, 0);
        chk("ar_waddr", rf_waddr, 0);
        model_reset();
        set_wb(1, 5'd6, 32'h66, 1, 5'd8, 32'h88);
        step();
        rst = 1'b1;
        step();
        chk("ar_tie_exu", rf_waddr, 6);
        idle(); repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24120013_rf_wb_arbiter.md
YSYX_24120013_RF_WB_ARBITER -- requirements
Module: ysyx_24120013_rf_wb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, SHALL set the register index width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the register data width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 iss_valid  in  1  SHALL flag that decode issues an instruction writing iss_rd.
REQ-006 iss_rd  in  ADDR_WIDTH  SHALL be the destination register of the issuing instruction.
REQ-007 iss_ready  out  1  SHALL be the issue acceptance (combinational).
REQ-008 rs1, rs2  in  ADDR_WIDTH each  SHALL be the source indices queried by decode.
REQ-009 rs1_busy, rs2_busy  out  1 each  SHALL flag a pending write to rs1/rs2 (combinational).
REQ-010 exu_valid, exu_rd, exu_data  in  1/ADDR_WIDTH/DATA_WIDTH  SHALL be the EXU writeback request.
REQ-011 exu_ready  out  1  SHALL be the EXU grant (combinational).
REQ-012 lsu_valid, lsu_rd, lsu_data  in  1/ADDR_WIDTH/DATA_WIDTH  SHALL be the LSU writeback request.
REQ-013 lsu_ready  out  1  SHALL be the LSU grant (combinational).
REQ-014 rf_wen, rf_waddr, rf_wdata  out  1/ADDR_WIDTH/DATA_WIDTH  SHALL drive the register file write port, registered.

Function
REQ-015 Scoreboard: 2**ADDR_WIDTH-bit pending vector; bit 0 SHALL be constant 0.
REQ-016 iss_ready SHALL be 1 when iss_rd==0 or pending[iss_rd]==0; else 0 (WAW stall).
REQ-017 On iss_valid & iss_ready with iss_rd!=0, pending[iss_rd] SHALL set at the clock edge.
REQ-018 rsN_busy SHALL equal pending[rsN]; rsN==0 SHALL always read 0.
REQ-019 Handshake: a writeback transfers in a cycle with valid & ready; requester SHALL hold rd/data stable while valid & !ready.
REQ-020 At most one of exu_ready/lsu_ready SHALL be 1 per cycle; ready SHALL never assert without matching valid.
REQ-021 Only one requester valid: it SHALL be granted that cycle (no bubble).
REQ-022 Both valid: round-robin; the requester not granted last SHALL win; 1-bit last-grant pointer updates on every transfer.
REQ-023 Transfer in cycle N SHALL produce rf_wen=1, rf_waddr=rd, rf_wdata=data in cycle N+1 (latency 1); no transfer -> rf_wen=0 in N+1, rf_waddr/rf_wdata hold.
REQ-024 Transfer with rd==0 SHALL complete the handshake but produce rf_wen=0.
REQ-025 On an edge where rf_wen==1, pending[rf_waddr] SHALL clear; busy drops the cycle after the register file write lands.
REQ-026 Set and clear of the same index on the same edge: set SHALL win.
REQ-027 Writeback to a non-pending rd SHALL commit normally; pending unaffected.
REQ-028 Sustained throughput SHALL be one writeback per cycle; writeback port never back-pressured downstream.

Reset
REQ-029 While rst==0: rf_wen=0, rf_waddr=0, rf_wdata=0, pending all 0, last-grant pointer = LSU (EXU wins first tie).
REQ-030 Reset assertion SHALL take effect immediately, independent of clk; in-flight registered writes SHALL be dropped.
REQ-031 While rst==0, exu_ready, lsu_ready SHALL be 0; iss_ready SHALL follow REQ-016 against the cleared scoreboard.
REQ-032 First edge after rst deasserts SHALL behave as normal operation.

Verification
REQ-033 Issue rd=5, then EXU wb rd=5 data=0xDEADBEEF -> rs1=5 busy from issue+1 until edge with rf_wen=1; rf_waddr=5, rf_wdata=0xDEADBEEF; busy=0 next cycle.
REQ-034 EXU and LSU valid every cycle, 4 cycles, rd=1..4 / 11..14 -> grants E,L,E,L; rf_waddr 1,11,2,12 on consecutive cycles.
REQ-035 pending[7]=1, iss_valid rd=7 -> iss_ready=0 until rd=7 commits; iss_rd=0 -> iss_ready=1, pending unchanged.
REQ-036 LSU wb rd=0 data=0x1234 -> lsu_ready=1, rf_wen=0 next cycle, rs1=0 busy=0.
REQ-037 Reset asserted asynchronously mid-cycle after a transfer -> rf_wen=0 without a clock edge, all busy=0; after release first tie grants EXU.
REQ-038 Random issue/writeback traffic -> scoreboard matches reference model; no double grant; every transfer commits exactly once.
